// File: rtl/button_pkg.sv
// Shared constants, FSM state type and priority encoder for the button encoder path.
// Pure declarations: no latency, no backpressure.
package button_pkg;

  localparam int NUM_BTN = 4;
  localparam int CODE_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } fsm_state_t;

  // Highest set index wins; an all-zero vector encodes to 0.
  function automatic logic [CODE_W-1:0] prio_enc(input logic [NUM_BTN-1:0] vec);
    logic [CODE_W-1:0] res;
    res = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (vec[i]) res = CODE_W'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button: 2-flop synchroniser plus debounce; latency 2 + DEBOUNCE_CYCLES cycles.
// No backpressure: the debounced level is always presented.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("debounce_cell: DEBOUNCE_CYCLES must be at least 2");
  end

  logic             sync1;
  logic             sync2;
  logic             state_q;
  logic [CNT_W-1:0] cnt;
  logic             sample;

  assign sample  = ~sync2;
  assign pressed = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      state_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      if (sample == state_q) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // DEBOUNCE_CYCLES-th consecutive differing sample: accept the new level.
        state_q <= sample;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_encoder.sv
// Debounced 4-button priority encoder; press to code_valid is 3 + DEBOUNCE_CYCLES cycles, no backpressure.
// Optional auto-repeat while held under BUTTON_ENCODER_REPEAT_EN.
module button_encoder
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int REPEAT_CYCLES   = 6000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [CODE_W-1:0]  code,
  output logic               code_valid,
  output logic               any_held
);

  logic [NUM_BTN-1:0] pressed;
  fsm_state_t         state;
  fsm_state_t         state_nxt;
  logic [CODE_W-1:0]  code_nxt;
  logic               code_valid_nxt;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_n  (btn_n[i]),
      .pressed(pressed[i])
    );
  end

`ifdef BUTTON_ENCODER_REPEAT_EN
  localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rpt_cnt <= '0;
    else     rpt_cnt <= rpt_nxt;
  end
`else
  if (REPEAT_CYCLES < 0) begin : g_bad_repeat
    $error("button_encoder: REPEAT_CYCLES must not be negative");
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      code       <= '0;
      code_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      code       <= code_nxt;
      code_valid <= code_valid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    code_nxt       = code;
    code_valid_nxt = 1'b0;
`ifdef BUTTON_ENCODER_REPEAT_EN
    rpt_nxt        = '0;
`endif
    case (state)
      IDLE: begin
        if (pressed != '0) begin
          state_nxt      = HELD;
          code_nxt       = prio_enc(pressed);
          code_valid_nxt = 1'b1;
        end
      end
      HELD: begin
        // Presses and releases of other buttons stay silent until all are released.
        if (pressed == '0) begin
          state_nxt = IDLE;
        end
`ifdef BUTTON_ENCODER_REPEAT_EN
        else if (rpt_cnt == RPT_MAX) begin
          code_nxt       = prio_enc(pressed);
          code_valid_nxt = 1'b1;
        end else begin
          rpt_nxt = rpt_cnt + 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign any_held = (state == HELD);

endmodule

// File: tb/tb_button_encoder.sv
// Table-driven bench for button_encoder (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10) with a strobe scoreboard.
module tb_button_encoder;

  localparam int DEB = 4;
  localparam int RPT = 10;
  localparam int LAT = 2 + DEB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_n;
  logic [1:0] code;
  logic       code_valid;
  logic       any_held;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int start;

  typedef struct {
    int         cyc;
    logic [1:0] code;
  } strobe_t;
  strobe_t sb[$];

  typedef struct {
    logic [3:0] btn;
    int         hold;
    logic       strobe;
    logic [1:0] code;
    logic       held;
  } vec_t;
  vec_t tbl[11];

  button_encoder #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (RPT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_n),
    .code      (code),
    .code_valid(code_valid),
    .any_held  (any_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [1:0] cd);
    strobe_t e;
    e.cyc  = c;
    e.code = cd;
    sb.push_back(e);
  endtask

  task automatic chk_drained(input string name);
    chk(name, sb.size(), 0);
    sb.delete();
  endtask

  // Every strobe must match the oldest outstanding expectation in cycle and code.
  always @(negedge clk) begin
    if (code_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        strobe_t e;
        e = sb.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("strobe_code", int'(code), int'(e.code));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'b1111, 50, 1'b0, 2'd0, 1'b0};  // idle after reset
    tbl[1]  = '{4'b1101, 12, 1'b1, 2'd1, 1'b1};  // single press btn1
    tbl[2]  = '{4'b1111, 12, 1'b0, 2'd1, 1'b0};  // release, code held
    tbl[3]  = '{4'b1011,  3, 1'b0, 2'd1, 1'b0};  // 3-cycle glitch on btn2
    tbl[4]  = '{4'b1111, 12, 1'b0, 2'd1, 1'b0};
    tbl[5]  = '{4'b0110, 12, 1'b1, 2'd3, 1'b1};  // simultaneous btn3+btn0
    tbl[6]  = '{4'b1110, 12, 1'b0, 2'd3, 1'b1};  // release btn3 only
    tbl[7]  = '{4'b1111, 12, 1'b0, 2'd3, 1'b0};
    tbl[8]  = '{4'b1110, 12, 1'b1, 2'd0, 1'b1};  // press btn0
    tbl[9]  = '{4'b1101, 12, 1'b0, 2'd0, 1'b1};  // release btn0 + press btn1 together
    tbl[10] = '{4'b1111, 12, 1'b0, 2'd0, 1'b0};

    rst   = 1'b1;
    btn_n = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_code", int'(code), 0);
    chk("reset_valid", int'(code_valid), 0);
    chk("reset_held", int'(any_held), 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      btn_n = tbl[i].btn;
      start = cyc;
      if (tbl[i].strobe) push(start + LAT, tbl[i].code);
      repeat (tbl[i].hold) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_code", i), int'(code), int'(tbl[i].code));
      chk($sformatf("vec%0d_held", i), int'(any_held), int'(tbl[i].held));
      chk_drained($sformatf("vec%0d_missing_strobe", i));
    end

    // Reset in the middle of a hold, buttons still pressed across release.
    btn_n = 4'b1100;
    start = cyc;
    push(start + LAT, 2'd1);
    repeat (9) @(posedge clk);
    #1;
    chk("prereset_held", int'(any_held), 1);
    rst = 1'b1;
    #1;
    chk("midhold_reset_code", int'(code), 0);
    chk("midhold_reset_valid", int'(code_valid), 0);
    chk("midhold_reset_held", int'(any_held), 0);
    chk_drained("prereset_missing_strobe");
    repeat (3) @(posedge clk);
    #1;
    btn_n = 4'b1110;
    rst   = 1'b0;
    start = cyc;
    push(start + LAT, 2'd0);
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk("requalify_not_early", int'(any_held), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("requalify_held", int'(any_held), 1);
    chk_drained("requalify_missing_strobe");
    btn_n = 4'b1111;
    repeat (12) @(posedge clk);
    #1;
    chk("requalify_release_held", int'(any_held), 0);

    // Long hold on btn2: repeats only when the optional feature is built in.
    btn_n = 4'b1011;
    start = cyc;
    push(start + LAT, 2'd2);
`ifdef BUTTON_ENCODER_REPEAT_EN
    for (int k = 1; k <= 4; k++) push(start + LAT + k * RPT, 2'd2);
`endif
    repeat (LAT + 4 * RPT + 1) @(posedge clk);
    #1;
    chk("long_hold_code", int'(code), 2);
    chk("long_hold_held", int'(any_held), 1);
    chk_drained("long_hold_missing_strobe");
    btn_n = 4'b1111;
    repeat (12) @(posedge clk);
    #1;
    chk("long_release_held", int'(any_held), 0);
    chk_drained("long_release_strobe");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
